// File: rtl/logic16_arbiter_if.sv
// Handshake bundle between two requesters, the shared And16 unit and the response consumer.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface logic16_arbiter_if #(
    parameter int unsigned WIDTH = 16
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic [WIDTH-1:0] lu_a;
    logic [WIDTH-1:0] lu_b;
    logic [WIDTH-1:0] lu_out;
    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ready;
    logic             busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output lu_a, lu_b,
        input  lu_out,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  lu_a, lu_b,
        output lu_out,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready,
        input  busy
    );
endinterface

// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one combinational And16 unit between two requesters,
// returning each result on a single tagged response channel.
module logic16_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input logic               clk,
    input logic               reset,
    logic16_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             cur_id_q, cur_id_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d;
    logic [WIDTH-1:0] lu_b_q, lu_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic gnt0, gnt1;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle) begin
            gnt0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
            gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        lu_a_d       = lu_a_q;
        lu_b_d       = lu_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (gnt0) begin
                    lu_a_d       = bus.req0_a;
                    lu_b_d       = bus.req0_b;
                    cur_id_d     = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = StExec;
                end else if (gnt1) begin
                    lu_a_d       = bus.req1_a;
                    lu_b_d       = bus.req1_b;
                    cur_id_d     = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = StExec;
                end
            end
            StExec: begin
                rsp_data_d  = bus.lu_out;
                rsp_id_d    = cur_id_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            cur_id_q     <= 1'b0;
            lu_a_q       <= '0;
            lu_b_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            lu_a_q       <= lu_a_d;
            lu_b_q       <= lu_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.lu_a       = lu_a_q;
    assign bus.lu_b       = lu_b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = (state_q != StIdle);
endmodule
